// File: rtl/ysyx_25020047_lsu_ctrl.sv
// Load/store unit controller: one request at a time over an aligned lane-wide memory bus.
// Optional macro YSYX_25020047_LSU_MISALIGN_TRAP_EN faults misaligned accesses instead of aligning them down.
module ysyx_25020047_lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_we,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rdata,
  output logic                  out_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = DATA_W'(64'h0000_0000_0000_00FF);
      2'd1:    lane_mask = DATA_W'(64'h0000_0000_0000_FFFF);
      2'd2:    lane_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: lane_mask = '1;
    endcase
  endfunction

  logic [1:0]        size_c;
  logic [OFF_W-1:0]  size_off_c;
  logic [OFF_W-1:0]  raw_off_c;
  logic [OFF_W-1:0]  acc_off_c;
  logic              illegal_c;
  logic              fault_c;
  logic [STRB_W-1:0] strb_base_c;

  always_comb begin
    size_c      = in_funct3[1:0];
    size_off_c  = OFF_W'((32'd1 << size_c) - 32'd1);
    raw_off_c   = in_addr[OFF_W-1:0];
    illegal_c   = (in_funct3 == 3'b111) ||
                  ((DATA_W == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
`ifdef YSYX_25020047_LSU_MISALIGN_TRAP_EN
    fault_c     = illegal_c || (|(raw_off_c & size_off_c));
    acc_off_c   = raw_off_c;
`else
    // Offset bits below the access size are dropped so the access stays inside its natural slot.
    fault_c     = illegal_c;
    acc_off_c   = raw_off_c & ~size_off_c;
`endif
    case (size_c)
      2'd0:    strb_base_c = STRB_W'(8'h01);
      2'd1:    strb_base_c = STRB_W'(8'h03);
      2'd2:    strb_base_c = STRB_W'(8'h0F);
      default: strb_base_c = STRB_W'(8'hFF);
    endcase
  end

  logic [DATA_W-1:0] rsp_sh_c;
  logic [DATA_W-1:0] rsp_mask_c;
  logic              rsp_msb_c;
  logic [DATA_W-1:0] load_c;

  always_comb begin
    rsp_sh_c   = mem_rsp_rdata >> {off_q, 3'b000};
    rsp_mask_c = lane_mask(funct3_q[1:0]);
    case (funct3_q[1:0])
      2'd0:    rsp_msb_c = rsp_sh_c[7];
      2'd1:    rsp_msb_c = rsp_sh_c[15];
      2'd2:    rsp_msb_c = rsp_sh_c[31];
      default: rsp_msb_c = rsp_sh_c[DATA_W-1];
    endcase
    load_c = (rsp_sh_c & rsp_mask_c) | ((rsp_msb_c && !funct3_q[2]) ? ~rsp_mask_c : '0);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          we_d     = in_we;
          funct3_d = in_funct3;
          off_d    = acc_off_c;
          addr_d   = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d  = (in_wdata & lane_mask(size_c)) << {acc_off_c, 3'b000};
          wstrb_d  = in_we ? (strb_base_c << acc_off_c) : '0;
          rdata_d  = '0;
          err_d    = fault_c;
          state_d  = fault_c ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // For stores the response is only a write acknowledge.
        if (mem_rsp_valid) begin
          rdata_d = we_q ? '0 : load_c;
          state_d = S_RESP;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_RESP);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

endmodule
